// File: rtl/comparador_pkg.sv
// Shared types for the MSB-first serial magnitude comparator.
// FSM state, (gt, lt) decision pair and the default operand width.
package comparador_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic gt;
        logic lt;
    } dec_t;

    localparam int WIDTH_DEF = 8;

endpackage

// File: rtl/comparador_serial_i_d_celda.sv
// Left-to-right comparator cell: the first differing bit decides
// the result, and an existing decision is never overturned.
module celda_tipica_i_d (
    input  logic i_gt,
    input  logic i_lt,
    input  logic i_a,
    input  logic i_b,
    output logic o_gt,
    output logic o_lt
);

    assign o_gt = i_gt | (~i_lt & i_a & ~i_b);
    assign o_lt = i_lt | (~i_gt & ~i_a & i_b);

endmodule

// File: rtl/comparador_serial_i_d.sv
// Bit-serial magnitude comparator, operands MSB first.
// One bit pair per accepted handshake; flags latched when the last pair is taken.
module comparador_serial_i_d
    import comparador_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic a_bit,
    input  logic b_bit,
    input  logic bit_valid,
    output logic bit_ready,
    output logic busy,
    output logic done,
    output logic a_gt_b,
    output logic a_lt_b,
    output logic a_eq_b
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t        r_state;
    state_t        w_next;
    logic [CW-1:0] r_cnt;
    dec_t          r_dec;
    logic          w_gt;
    logic          w_lt;
    logic          w_acc;
    logic          w_last;
    logic          w_enter;
    logic          r_gt;
    logic          r_lt;
    logic          r_eq;

    celda_tipica_i_d u_celda (
        .i_gt (r_dec.gt),
        .i_lt (r_dec.lt),
        .i_a  (a_bit),
        .i_b  (b_bit),
        .o_gt (w_gt),
        .o_lt (w_lt)
    );

    assign w_acc   = bit_valid && (r_state == RUN);
    assign w_last  = w_acc && (r_cnt == CW'(WIDTH - 1));
    assign w_enter = (w_next == RUN) && (r_state != RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (start) w_next = RUN;
            RUN:     if (w_last) w_next = DONE;
            DONE:    w_next = start ? RUN : IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Decided bits keep being consumed so the stream stays aligned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_dec <= '0;
        end else if (w_enter) begin
            r_cnt <= '0;
            r_dec <= '0;
        end else if (w_acc) begin
            r_cnt <= r_cnt + CW'(1);
            r_dec <= '{gt: w_gt, lt: w_lt};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gt <= 1'b0;
            r_lt <= 1'b0;
            r_eq <= 1'b0;
        end else if (w_last) begin
            r_gt <= w_gt;
            r_lt <= w_lt;
            r_eq <= ~w_gt & ~w_lt;
        end
    end

    always_comb begin
        bit_ready = (r_state == RUN);
        busy      = (r_state == RUN);
        done      = (r_state == DONE);
        a_gt_b    = r_gt;
        a_lt_b    = r_lt;
        a_eq_b    = r_eq;
    end

endmodule

// File: tb/tb_comparador_serial_i_d.sv
// Scoreboard bench for comparador_serial_i_d (WIDTH=8).
// Driver pushes hand-computed results; a monitor checks each done pulse.
module tb_comparador_serial_i_d;

    logic clk;
    logic rst_n;
    logic start;
    logic a_bit;
    logic b_bit;
    logic bit_valid;
    logic bit_ready;
    logic busy;
    logic done;
    logic a_gt_b;
    logic a_lt_b;
    logic a_eq_b;

    typedef struct {
        logic gt;
        logic lt;
        logic eq;
        int   t0;
        int   lat;
    } exp_t;

    exp_t q[$];
    int   checks;
    int   errors;
    int   cyc;
    int   n_done;

    comparador_serial_i_d #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .a_bit     (a_bit),
        .b_bit     (b_bit),
        .bit_valid (bit_valid),
        .bit_ready (bit_ready),
        .busy      (busy),
        .done      (done),
        .a_gt_b    (a_gt_b),
        .a_lt_b    (a_lt_b),
        .a_eq_b    (a_eq_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && done) begin
            exp_t e;
            n_done++;
            if (q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                e = q.pop_front();
                chk("a_gt_b", int'(a_gt_b), int'(e.gt));
                chk("a_lt_b", int'(a_lt_b), int'(e.lt));
                chk("a_eq_b", int'(a_eq_b), int'(e.eq));
                chk("latency", cyc - e.t0 + 1, e.lat);
            end
        end
    end

    // pulse_at: bit index (0=MSB) issued together with a start pulse.
    // abort_at: number of accepted bits before rst_n is pulled low.
    task automatic run_cmp(
        input logic [7:0] a,
        input logic [7:0] b,
        input logic       egt,
        input logic       elt,
        input logic       eeq,
        input int         lat,
        input int         stall_at,
        input int         stall_n,
        input int         pulse_at,
        input int         abort_at,
        input bit         b2b
    );
        exp_t e;
        if (!b2b) @(negedge clk);
        start = 1'b1;
        if (abort_at < 0) begin
            e = '{gt: egt, lt: elt, eq: eeq, t0: cyc + 1, lat: lat};
            q.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (k == abort_at) begin
                rst_n = 1'b0;
                #1;
                chk("rst_busy", int'(busy), 0);
                chk("rst_ready", int'(bit_ready), 0);
                chk("rst_done", int'(done), 0);
                chk("rst_flags", int'({a_gt_b, a_lt_b, a_eq_b}), 0);
                bit_valid = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            if (k == stall_at) begin
                bit_valid = 1'b0;
                repeat (stall_n) @(negedge clk);
            end
            chk("bit_ready", int'(bit_ready), 1);
            a_bit     = a[7-k];
            b_bit     = b[7-k];
            bit_valid = 1'b1;
            start     = (k == pulse_at);
            @(negedge clk);
        end
        bit_valid = 1'b0;
        start     = 1'b0;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        cyc       = 0;
        n_done    = 0;
        rst_n     = 1'b0;
        start     = 1'b0;
        a_bit     = 1'b0;
        b_bit     = 1'b0;
        bit_valid = 1'b0;
        #1;
        chk("reset_done", int'(done), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_flags", int'({a_gt_b, a_lt_b, a_eq_b}), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        run_cmp(8'hA5, 8'hA5, 0, 0, 1, 9, -1, 0, -1, -1, 0);
        repeat (3) @(negedge clk);
        chk("hold_eq", int'({a_gt_b, a_lt_b, a_eq_b}), 1);
        chk("idle_busy", int'(busy), 0);

        run_cmp(8'h80, 8'h7F, 1, 0, 0, 9, -1, 0, -1, -1, 0);
        run_cmp(8'h01, 8'h02, 0, 1, 0, 12, 4, 3, -1, -1, 0);

        run_cmp(8'hFF, 8'h00, 0, 0, 0, 0, -1, 0, -1, 4, 0);
        a_bit     = 1'b1;
        b_bit     = 1'b0;
        bit_valid = 1'b1;
        repeat (3) @(negedge clk);
        bit_valid = 1'b0;
        chk("idle_valid_ignored", int'(busy), 0);
        run_cmp(8'h10, 8'h0F, 1, 0, 0, 9, -1, 0, -1, -1, 0);

        run_cmp(8'h3C, 8'h3D, 0, 1, 0, 9, -1, 0, 3, -1, 0);
        run_cmp(8'h55, 8'h55, 0, 0, 1, 9, -1, 0, 7, -1, 0);

        run_cmp(8'h03, 8'h05, 0, 1, 0, 9, -1, 0, -1, -1, 0);
        run_cmp(8'hFF, 8'hFE, 1, 0, 0, 9, -1, 0, -1, -1, 1);

        for (int i = 0; i < 40 && q.size() != 0; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        chk("queue_drained", q.size(), 0);
        chk("done_count", n_done, 8);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/comparador_serial_i_d.md
# comparador_serial_i_d

- Bit-serial magnitude comparator that consumes operands A and B most-significant bit first (left-to-right, izquierda-derecha).
- Complements the existing right-to-left comparator cell chain: same comparison, opposite scan direction.
- Accepts one bit pair per handshake, tracks a decided/undecided state, and reports greater / less / equal after WIDTH bits.
- Sits between a serial operand source (shift register or link) and the control logic that consumes the comparison flags.

## Interface
- WIDTH, 8, number of bits per operand; legal range 1..64.
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begin a new comparison; sampled only in IDLE or DONE.
- a_bit  in  1  current bit of A, MSB first.
- b_bit  in  1  current bit of B, MSB first.
- bit_valid  in  1  a_bit/b_bit are valid this cycle.
- bit_ready  out  1  block accepts a bit pair this cycle; high exactly in RUN.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse; result valid.
- a_gt_b  out  1  registered result, A > B.
- a_lt_b  out  1  registered result, A < B.
- a_eq_b  out  1  registered result, A == B.

## Operation
- FSM states: IDLE, RUN, DONE.
- Transitions:
  - IDLE: start=1 → RUN.
  - RUN: accept on bit_valid & bit_ready. When the WIDTH-th pair is accepted → DONE.
  - DONE: start=1 → RUN (back-to-back), else → IDLE.
- Internal state pair (gt, lt):
  - Cleared to (0,0) on entry to RUN.
  - Per accepted pair, if undecided (gt=lt=0): a=1,b=0 → gt=1; a=0,b=1 → lt=1; equal bits → unchanged.
  - Once decided, the state is frozen. Remaining bits are still consumed to keep stream alignment; there is no early exit.
  - Cell equations: gt' = gt | (~lt & a & ~b); lt' = lt | (~gt & ~a & b).
- Bit counter:
  - Width $clog2(WIDTH+1); cleared on RUN entry, +1 per accepted pair.
  - Terminal count is WIDTH-1 at acceptance.
- Results:
  - a_gt_b=gt', a_lt_b=lt', a_eq_b=~gt'&~lt', all loaded on the RUN→DONE transition.
  - Held stable until the next DONE; not cleared by start.
  - Exactly one result flag is high after the first completed comparison.
- Boundary and exception behaviour:
  - start in RUN is ignored.
  - bit_valid outside RUN is ignored.
  - bit_valid low in RUN stalls: no count or state change.
  - start and the final bit in the same cycle: start ignored, since the FSM is in RUN.
  - WIDTH=1: a single accepted pair → DONE.
- Reset (asynchronous, any state, including mid-RUN):
  - FSM → IDLE; counter=0; gt=lt=0.
  - bit_ready=busy=done=0; a_gt_b=a_lt_b=a_eq_b=0.

## Timing
- start sampled at edge N → RUN; bit_ready=1 from cycle N+1.
- One pair per cycle at most. With bit_valid held high, the last pair is accepted at edge N+WIDTH.
- done=1 and results updated in cycle N+WIDTH+1 (DONE); latency = WIDTH+1 cycles from start when there are no stalls.
- Each stall cycle adds one cycle.
- Back-to-back: start in DONE gives RUN the next cycle, so WIDTH+1 cycles per comparison.
- done is high for exactly one cycle per comparison.
- All outputs are registered or decoded from the FSM state; no combinational path from inputs to outputs.

## Structure
- Shared package comparador_pkg:
  - FSM state typedef (IDLE, RUN, DONE).
  - Typedef for the (gt, lt) decision pair.
  - Default-WIDTH constant.
- Natural sub-module: celda_tipica_i_d.
  - Combinational left-to-right cell: inputs gt, lt, a, b; outputs gt', lt' per the equations above.
  - Instantiated once; its outputs feed the state register.
- Top level holds the FSM, counter, state and result registers.

## Test plan
- WIDTH=8, A=0xA5, B=0xA5, bit_valid held high → done at cycle 9 after start; a_eq_b=1, a_gt_b=a_lt_b=0.
- A=0x80, B=0x7F → decided at the first bit; all 8 bits still consumed; done at cycle 9; a_gt_b=1.
- A=0x01, B=0x02 with bit_valid low for 3 cycles after bit 4 → done at cycle 12; a_lt_b=1.
- rst_n low after 4 accepted bits → all outputs 0 immediately. New start, A=0x10, B=0x0F → a_gt_b=1, with no residue from the aborted run.
- start pulsed during RUN → ignored; bit count and result unaffected; done pulses once.
- Back-to-back: start in the DONE cycle of A=0x03, B=0x05 (lt), then A=0xFF, B=0xFE → two done pulses 9 cycles apart; results lt then gt.
